// File: rtl/opcode_sequencer.sv
// Fetch/sequence unit: walks pc, fetches instruction words over req/ack and
// presents a one-hot opcode for the control ROM for one cycle per instruction.
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | imem_req asserted at pc until imem_ack
// EXEC  | one cycle: opcode_onehot/op_valid valid, pc advanced
// HALT  | HALT opcode executed; start restarts from pc 0
module opcode_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    input  logic            above_flag,
    output logic [63:0]     opcode_onehot,
    output logic            op_valid,
    output logic            illegal,
    output logic            halted,
    output logic [15:0]     retired
);

    localparam logic [5:0] OP_ADD  = 6'd4;
    localparam logic [5:0] OP_MOVL = 6'd11;
    localparam logic [5:0] OP_MOVS = 6'd13;
    localparam logic [5:0] OP_JA   = 6'd14;
    localparam logic [5:0] OP_AND  = 6'd37;
    localparam logic [5:0] OP_CMP  = 6'd59;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic [31:0]     ir;
    logic            ir_load;
    logic [15:0]     retired_next;
    logic [5:0]      opcode;
    logic            op_legal;

    assign opcode = ir[31:26];

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_ADD, OP_MOVL, OP_MOVS, OP_JA, OP_AND, OP_CMP, OP_HALT: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Instruction bits between the JA target and the opcode are unused here.
    generate
        if (PC_W < 26) begin : g_unused_ir
            logic unused_ir_bits;
            assign unused_ir_bits = ^ir[25:PC_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            retired <= retired_next;
            if (ir_load) begin
                ir <= imem_data;
            end
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        retired_next = retired;
        ir_load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                retired_next = retired + 16'd1;
                if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                    if (opcode == OP_JA && above_flag) pc_next = ir[PC_W-1:0];
                    else                               pc_next = pc + 1'b1;
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_next      = '0;
                    retired_next = '0;
                    state_next   = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decode only from registered state/ir so ack and above_flag never reach them.
    assign imem_req      = (state == S_FETCH);
    assign imem_addr     = pc;
    assign op_valid      = (state == S_EXEC);
    assign opcode_onehot = op_valid ? (64'd1 << opcode) : 64'd0;
    assign illegal       = op_valid && !op_legal;
    assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_opcode_sequencer.sv
// Scoreboard bench for opcode_sequencer: directed programs push the expected
// EXEC opcodes; a negedge monitor pops and compares whenever op_valid is high.
module tb_opcode_sequencer;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_data;
    logic            above_flag;
    logic [63:0]     opcode_onehot;
    logic            op_valid;
    logic            illegal;
    logic            halted;
    logic [15:0]     retired;

    opcode_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .above_flag(above_flag),
        .opcode_onehot(opcode_onehot), .op_valid(op_valid), .illegal(illegal),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       ill;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [256];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        ack_hold = 1'b0;
    logic        ack_force = 1'b0;

    assign imem_data = mem[imem_addr];
    assign imem_ack  = ack_force | (imem_req && !ack_hold && (wait_cnt >= ack_delay));

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic ill);
        exp_t e;
        e.op  = op;
        e.ill = ill;
        sb.push_back(e);
    endtask

    // Monitor: compare every EXEC against the scoreboard, and idle outputs otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            if (op_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_exec: got onehot %0h, expected no EXEC", opcode_onehot);
                end else begin
                    exp_t e;
                    logic [63:0] want;
                    e = sb.pop_front();
                    want = 64'd1 << e.op;
                    check("exec_onehot", opcode_onehot, want);
                    check("exec_illegal", {63'd0, illegal}, {63'd0, e.ill});
                end
            end else begin
                check("idle_onehot", opcode_onehot, 64'd0);
                check("idle_illegal", {63'd0, illegal}, 64'd0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!halted) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: halted got 0 expected 1", name);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hFC000000;
        reset = 1'b1;
        start = 1'b0;
        above_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_addr", {56'd0, imem_addr}, 64'd0);
        check("rst_valid", {63'd0, op_valid}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_retired", {48'd0, retired}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req", {63'd0, imem_req}, 64'd0);

        // Straight-line ADD, AND, HALT with zero wait states.
        mem[0] = 32'h10000000; mem[1] = 32'h94000000; mem[2] = 32'hFC000000;
        push(6'd4, 1'b0); push(6'd37, 1'b0); push(6'd63, 1'b0);
        pulse_start();
        check("start_req", {63'd0, imem_req}, 64'd1);
        wait_halt("straight");
        check("straight_pc", {56'd0, imem_addr}, 64'd2);
        check("straight_retired", {48'd0, retired}, 64'd3);

        // Restart from HALT into CMP, HALT.
        mem[0] = 32'hEC000000; mem[1] = 32'hFC000000;
        push(6'd59, 1'b0); push(6'd63, 1'b0);
        pulse_start();
        check("restart_halted", {63'd0, halted}, 64'd0);
        check("restart_retired", {48'd0, retired}, 64'd0);
        check("restart_req", {63'd0, imem_req}, 64'd1);
        check("restart_addr", {56'd0, imem_addr}, 64'd0);
        wait_halt("restart");
        check("restart_final_retired", {48'd0, retired}, 64'd2);

        // Three wait states on the fetch at address 0.
        mem[0] = 32'h10000000; mem[1] = 32'hFC000000;
        ack_delay = 3;
        push(6'd4, 1'b0); push(6'd63, 1'b0);
        pulse_start();
        begin
            int cnt = 0;
            while (imem_req && imem_addr == 0 && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            check("wait_req_cycles", 64'(cnt), 64'd4);
            check("wait_exec_valid", {63'd0, op_valid}, 64'd1);
        end
        wait_halt("wait");
        ack_delay = 0;

        // JA taken then not taken.
        mem[0] = 32'h10000000; mem[1] = 32'h38000005;
        mem[2] = 32'hFC000000; mem[5] = 32'hFC000000;
        above_flag = 1'b1;
        push(6'd4, 1'b0); push(6'd14, 1'b0); push(6'd63, 1'b0);
        pulse_start();
        wait_halt("ja_taken");
        check("ja_taken_addr", {56'd0, imem_addr}, 64'd5);
        above_flag = 1'b0;
        push(6'd4, 1'b0); push(6'd14, 1'b0); push(6'd63, 1'b0);
        pulse_start();
        wait_halt("ja_not_taken");
        check("ja_not_taken_addr", {56'd0, imem_addr}, 64'd2);

        // Jump to 0xFF, illegal opcode there, pc wraps to 0.
        mem[0] = 32'h380000FF; mem[1] = 32'hFC000000; mem[255] = 32'h04000000;
        above_flag = 1'b1;
        push(6'd14, 1'b0); push(6'd1, 1'b1); push(6'd14, 1'b0); push(6'd63, 1'b0);
        pulse_start();
        begin
            int n = 0;
            while (!illegal && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("illegal_seen", {63'd0, illegal}, 64'd1);
            check("illegal_addr", {56'd0, imem_addr}, 64'd255);
            above_flag = 1'b0;
            @(negedge clk);
            check("illegal_pulse_end", {63'd0, illegal}, 64'd0);
            check("wrap_addr", {56'd0, imem_addr}, 64'd0);
            check("wrap_req", {63'd0, imem_req}, 64'd1);
        end
        wait_halt("wrap");
        check("wrap_final_pc", {56'd0, imem_addr}, 64'd1);
        check("wrap_retired", {48'd0, retired}, 64'd4);

        // Reset mid-fetch, with ack arriving in the same cycle as reset.
        ack_hold = 1'b1;
        pulse_start();
        @(negedge clk);
        check("midfetch_req", {63'd0, imem_req}, 64'd1);
        reset = 1'b1;
        ack_force = 1'b1;
        @(negedge clk);
        check("rst2_req", {63'd0, imem_req}, 64'd0);
        check("rst2_addr", {56'd0, imem_addr}, 64'd0);
        check("rst2_onehot", opcode_onehot, 64'd0);
        check("rst2_valid", {63'd0, op_valid}, 64'd0);
        check("rst2_illegal", {63'd0, illegal}, 64'd0);
        check("rst2_halted", {63'd0, halted}, 64'd0);
        check("rst2_retired", {48'd0, retired}, 64'd0);
        reset = 1'b0;
        ack_force = 1'b0;
        ack_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_stays_idle", {63'd0, imem_req}, 64'd0);
        check("rst2_no_exec", {63'd0, op_valid}, 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
